// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and legality definitions for the ALU arbiter and its ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB, OP_NOR: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU shared by the arbiter; unknown selects produce zero.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] alu_out
);

    always_comb begin
        alu_out = '0;
        case (alu_sel)
            OP_AND:   alu_out = a & b;
            OP_OR:    alu_out = a | b;
            OP_ADD:   alu_out = a + b;
            OP_SUB:   alu_out = a - b;
            OP_PASSB: alu_out = b;
            OP_NOR:   alu_out = ~(a | b);
            default:  alu_out = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters,
// with a registered per-requester response channel and a completion counter.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [3:0]       r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    output logic [WIDTH-1:0] r0_rsp_result,
    output logic             r0_rsp_zero,
    output logic             r0_rsp_err,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [3:0]       r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [WIDTH-1:0] r1_rsp_result,
    output logic             r1_rsp_zero,
    output logic             r1_rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t           state, state_next;
    logic             rr_ptr, cur_id, grant_id, any_valid, accept, rsp_hs;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y, exec_result;
    logic             exec_legal;

    alu #(.WIDTH(WIDTH)) u_alu (
        .alu_sel (alu_sel),
        .a       (alu_a),
        .b       (alu_b),
        .alu_out (alu_y)
    );

    // A lone requester wins outright; a tie goes to the requester named by rr_ptr.
    assign any_valid   = r0_valid | r1_valid;
    assign grant_id    = (r0_valid && r1_valid) ? rr_ptr : r1_valid;
    assign accept      = (state == ST_IDLE) && any_valid;
    assign rsp_hs      = (state == ST_RESP) &&
                         (cur_id ? (r1_rsp_valid && r1_rsp_ready)
                                 : (r0_rsp_valid && r0_rsp_ready));
    assign exec_legal  = op_legal(alu_sel);
    assign exec_result = exec_legal ? alu_y : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (any_valid) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (rsp_hs) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        r0_ready = (state == ST_IDLE) && r0_valid && !grant_id;
        r1_ready = (state == ST_IDLE) && r1_valid && grant_id;
    end

    // ALU inputs only change on accept so the shared datapath is quiet otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= 1'b0;
            cur_id  <= 1'b0;
            alu_sel <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
        end else if (accept) begin
            rr_ptr  <= ~grant_id;
            cur_id  <= grant_id;
            alu_sel <= grant_id ? r1_op : r0_op;
            alu_a   <= grant_id ? r1_a  : r0_a;
            alu_b   <= grant_id ? r1_b  : r0_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_rsp_valid  <= 1'b0;
            r0_rsp_result <= '0;
            r0_rsp_zero   <= 1'b0;
            r0_rsp_err    <= 1'b0;
            r1_rsp_valid  <= 1'b0;
            r1_rsp_result <= '0;
            r1_rsp_zero   <= 1'b0;
            r1_rsp_err    <= 1'b0;
            op_count      <= '0;
        end else begin
            if (state == ST_EXEC) begin
                if (cur_id) begin
                    r1_rsp_valid  <= 1'b1;
                    r1_rsp_result <= exec_result;
                    r1_rsp_zero   <= (exec_result == '0);
                    r1_rsp_err    <= ~exec_legal;
                end else begin
                    r0_rsp_valid  <= 1'b1;
                    r0_rsp_result <= exec_result;
                    r0_rsp_zero   <= (exec_result == '0);
                    r0_rsp_err    <= ~exec_legal;
                end
            end
            if (rsp_hs) begin
                if (cur_id) r1_rsp_valid <= 1'b0;
                else        r0_rsp_valid <= 1'b0;
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule
